mips_mc_control: RTL and testbench

Multi-cycle control FSM for the Small_MIPS core. It sequences the shared ALU, register file, instruction register and unified memory port. Each instruction moves through fetch, decode, execute, memory and writeback steps, and the FSM drives the ALU `ar_op` code and all datapath mux and enable lines. It supports ADDIU, ADDU, JR, LW, SW and NOP, counts retired instructions, and traps on illegal encodings or memory timeouts.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/mips_decode.sv | 34 +++
 rtl/mips_mc_control.sv | 189 ++++++++++++++++++
 tb/tb_mips_mc_control.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the Small_MIPS multi-cycle control path:
// opcodes, ALU operation codes, FSM states and datapath select values.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;

    localparam logic [5:0] AR_ADD     = 6'b100001;
    localparam logic [5:0] AR_LW      = 6'b100011;
    localparam logic [5:0] AR_SW      = 6'b101011;
    localparam logic [5:0] AR_NOP     = 6'b000000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_JUMP,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALU_B_REG  = 2'd0,
        ALU_B_FOUR = 2'd1,
        ALU_B_IMM  = 2'd2
    } alu_src_b_t;

    typedef enum logic {
        PC_SRC_ALU = 1'b0,
        PC_SRC_REG = 1'b1
    } pc_src_t;

    // Instructions that pass through EXEC; remembered past DECODE.
    typedef enum logic [1:0] {
        EX_ADDU,
        EX_ADDIU,
        EX_LW,
        EX_SW
    } exec_kind_t;

    typedef struct packed {
        logic nop;
        logic addu;
        logic addiu;
        logic lw;
        logic sw;
        logic jr;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/mips_decode.sv
// Combinational classifier: instruction word to a one-hot instruction class.
module mips_decode
    import mips_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        cls = '0;
        if (instr == '0) begin
            cls.nop = 1'b1;
        end else begin
            case (opcode)
                OP_SPECIAL: begin
                    if (funct == FN_JR)        cls.jr      = 1'b1;
                    else if (funct == FN_ADDU) cls.addu    = 1'b1;
                    else                       cls.illegal = 1'b1;
                end
                OP_ADDIU: cls.addiu   = 1'b1;
                OP_LW:    cls.lw      = 1'b1;
                OP_SW:    cls.sw      = 1'b1;
                default:  cls.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle control FSM for Small_MIPS: sequences fetch/decode/execute/
// memory/writeback, counts retired instructions and traps on faults.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             mdr_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [5:0]       ar_op,
    output logic             alu_out_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [RET_W-1:0] retired
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    instr_class_t      dec_cls;
    exec_kind_t        exec_q;
    exec_kind_t        exec_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              timeout;
    logic              retire;

    mips_decode u_decode (
        .instr (instr),
        .cls   (dec_cls)
    );

    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                     (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        if (dec_cls.addu)       exec_d = EX_ADDU;
        else if (dec_cls.addiu) exec_d = EX_ADDIU;
        else if (dec_cls.lw)    exec_d = EX_LW;
        else                    exec_d = EX_SW;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Wait counter restarts whenever a wait state is entered or left.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            retired  <= '0;
            exec_q   <= EX_ADDU;
        end else begin
            if (in_wait && (state_next == state)) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                                  wait_cnt <= '0;
            if (retire)                           retired  <= retired + RET_W'(1);
            if (state == S_DECODE)                exec_q   <= exec_d;
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_next = S_DECODE;
                else if (timeout) state_next = S_TRAP;
            end
            S_DECODE: begin
                if (dec_cls.nop) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (dec_cls.jr) begin
                    state_next = S_JUMP;
                end else if (dec_cls.addu || dec_cls.addiu || dec_cls.lw || dec_cls.sw) begin
                    state_next = S_EXEC;
                end else if (dec_cls.illegal) begin
                    state_next = S_TRAP;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC: begin
                case (exec_q)
                    EX_LW:   state_next = S_MEM_RD;
                    EX_SW:   state_next = S_MEM_WR;
                    default: state_next = S_WB_ALU;
                endcase
            end
            S_MEM_RD: begin
                if (mem_ready)    state_next = S_WB_MEM;
                else if (timeout) state_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (timeout) begin
                    state_next = S_TRAP;
                end
            end
            S_WB_ALU, S_WB_MEM, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_src        = PC_SRC_ALU;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        mdr_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_B_REG;
        ar_op         = AR_NOP;
        alu_out_write = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        trap          = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_B_FOUR;
                ar_op     = AR_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_EXEC: begin
                alu_src_a     = 1'b1;
                alu_out_write = 1'b1;
                case (exec_q)
                    EX_ADDU:  begin alu_src_b = ALU_B_REG; ar_op = AR_ADD; end
                    EX_ADDIU: begin alu_src_b = ALU_B_IMM; ar_op = AR_ADD; end
                    EX_LW:    begin alu_src_b = ALU_B_IMM; ar_op = AR_LW;  end
                    default:  begin alu_src_b = ALU_B_IMM; ar_op = AR_SW;  end
                endcase
            end
            S_MEM_RD: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                mdr_write = mem_ready;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (exec_q == EX_ADDU);
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_REG;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: per-cycle control words from a
// table of instruction vectors plus hand-written trap/timeout/reset sequences.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, iord, mdr_write;
    logic        alu_src_a, alu_out_write, reg_write, reg_dst, mem_to_reg, trap;
    logic [1:0]  alu_src_b;
    logic [5:0]  ar_op;
    logic [3:0]  retired;

    always #5 clk = ~clk;

    mips_mc_control #(.MEM_TIMEOUT(4), .RET_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .mdr_write     (mdr_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .ar_op         (ar_op),
        .alu_out_write (alu_out_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .trap          (trap),
        .retired       (retired)
    );

    logic [20:0] dut_word;
    assign dut_word = {pc_write, pc_src, ir_write, mem_read, mem_write, iord, mdr_write,
                       alu_src_a, alu_src_b, ar_op, alu_out_write, reg_write, reg_dst,
                       mem_to_reg, trap};

    function automatic logic [20:0] ctl(input logic pcw, pcs, irw, mr, mw, io, mdr, asa,
                                        input logic [1:0] asb, input logic [5:0] op,
                                        input logic aow, rw, rd, m2r, tr);
        return {pcw, pcs, irw, mr, mw, io, mdr, asa, asb, op, aow, rw, rd, m2r, tr};
    endfunction

    localparam logic [20:0] W_ZERO       = '0;
    localparam logic [20:0] W_FETCH_WAIT = ctl(0,0,0,1,0,0,0,0, 2'd1, 6'b100001, 0,0,0,0,0);
    localparam logic [20:0] W_FETCH_RDY  = ctl(1,0,1,1,0,0,0,0, 2'd1, 6'b100001, 0,0,0,0,0);
    localparam logic [20:0] W_DECODE     = '0;
    localparam logic [20:0] W_EXEC_ADDU  = ctl(0,0,0,0,0,0,0,1, 2'd0, 6'b100001, 1,0,0,0,0);
    localparam logic [20:0] W_EXEC_ADDIU = ctl(0,0,0,0,0,0,0,1, 2'd2, 6'b100001, 1,0,0,0,0);
    localparam logic [20:0] W_EXEC_LW    = ctl(0,0,0,0,0,0,0,1, 2'd2, 6'b100011, 1,0,0,0,0);
    localparam logic [20:0] W_EXEC_SW    = ctl(0,0,0,0,0,0,0,1, 2'd2, 6'b101011, 1,0,0,0,0);
    localparam logic [20:0] W_MRD_WAIT   = ctl(0,0,0,1,0,1,0,0, 2'd0, 6'b000000, 0,0,0,0,0);
    localparam logic [20:0] W_MRD_RDY    = ctl(0,0,0,1,0,1,1,0, 2'd0, 6'b000000, 0,0,0,0,0);
    localparam logic [20:0] W_MWR        = ctl(0,0,0,0,1,1,0,0, 2'd0, 6'b000000, 0,0,0,0,0);
    localparam logic [20:0] W_WB_ADDU    = ctl(0,0,0,0,0,0,0,0, 2'd0, 6'b000000, 0,1,1,0,0);
    localparam logic [20:0] W_WB_ADDIU   = ctl(0,0,0,0,0,0,0,0, 2'd0, 6'b000000, 0,1,0,0,0);
    localparam logic [20:0] W_WB_MEM     = ctl(0,0,0,0,0,0,0,0, 2'd0, 6'b000000, 0,1,0,1,0);
    localparam logic [20:0] W_JUMP       = ctl(1,1,0,0,0,0,0,0, 2'd0, 6'b000000, 0,0,0,0,0);
    localparam logic [20:0] W_TRAP       = ctl(0,0,0,0,0,0,0,0, 2'd0, 6'b000000, 0,0,0,0,1);

    typedef enum {K_NOP, K_ADDU, K_ADDIU, K_LW, K_SW, K_JR} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] instr;
        int          fstall;
        int          mstall;
    } vec_t;
    typedef struct {
        string       name;
        logic [20:0] w;
    } exp_t;

    vec_t        vecs[9];
    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [3:0]  ret_model;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    // One clock cycle: drive mem_ready, queue the expected control word,
    // compare at the falling edge, then move to just after the next rising edge.
    task automatic step(input logic rdy, input logic [20:0] w, input string nm);
        exp_t e;
        mem_ready = rdy;
        sb.push_back('{nm, w});
        @(negedge clk);
        e = sb.pop_front();
        check(e.name, {11'b0, dut_word}, {11'b0, e.w});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        instr     = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_ctl", {11'b0, dut_word}, 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_trap", 32'(trap), 32'd0);
        rst       = 1'b0;
        ret_model = '0;
        step(rnd(), W_ZERO, "idle");
    endtask

    task automatic run_vec(input vec_t v);
        instr = v.instr;
        repeat (v.fstall) step(1'b0, W_FETCH_WAIT, {v.name, "_fetch_wait"});
        step(1'b1, W_FETCH_RDY, {v.name, "_fetch"});
        step(rnd(), W_DECODE, {v.name, "_decode"});
        // IR content past DECODE must not affect sequencing.
        instr = $urandom;
        case (v.kind)
            K_JR:    step(rnd(), W_JUMP, {v.name, "_jump"});
            K_ADDU: begin
                step(rnd(), W_EXEC_ADDU, {v.name, "_exec"});
                step(rnd(), W_WB_ADDU, {v.name, "_wb"});
            end
            K_ADDIU: begin
                step(rnd(), W_EXEC_ADDIU, {v.name, "_exec"});
                step(rnd(), W_WB_ADDIU, {v.name, "_wb"});
            end
            K_LW: begin
                step(rnd(), W_EXEC_LW, {v.name, "_exec"});
                repeat (v.mstall) step(1'b0, W_MRD_WAIT, {v.name, "_mrd_wait"});
                step(1'b1, W_MRD_RDY, {v.name, "_mrd"});
                step(rnd(), W_WB_MEM, {v.name, "_wb"});
            end
            K_SW: begin
                step(rnd(), W_EXEC_SW, {v.name, "_exec"});
                repeat (v.mstall) step(1'b0, W_MWR, {v.name, "_mwr_wait"});
                step(1'b1, W_MWR, {v.name, "_mwr"});
            end
            default: ;
        endcase
        ret_model = ret_model + 4'd1;
        check({v.name, "_retired"}, 32'(retired), 32'(ret_model));
    endtask

    logic [31:0] illegal_enc[2];

    initial begin
        vecs[0] = '{"addu",      K_ADDU,  32'h00221821, 0, 0};
        vecs[1] = '{"lw_stall3", K_LW,    32'h8C220004, 0, 3};
        vecs[2] = '{"sw_stall2", K_SW,    32'hAC220008, 0, 2};
        vecs[3] = '{"jr",        K_JR,    32'h00200008, 0, 0};
        vecs[4] = '{"nop",       K_NOP,   32'h00000000, 0, 0};
        vecs[5] = '{"addiu",     K_ADDIU, 32'h24420005, 2, 0};
        vecs[6] = '{"lw_limit",  K_LW,    32'h8C220004, 4, 4};
        vecs[7] = '{"sw_limit",  K_SW,    32'hAC220008, 1, 4};
        vecs[8] = '{"jr_r31",    K_JR,    32'h03E00008, 0, 0};
        illegal_enc[0] = 32'hFC000000;
        illegal_enc[1] = 32'h00000001;

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i]);

        foreach (illegal_enc[i]) begin
            instr = illegal_enc[i];
            step(1'b1, W_FETCH_RDY, "ill_fetch");
            step(rnd(), W_DECODE, "ill_decode");
            repeat (20) step(rnd(), W_TRAP, "ill_trap_hold");
            check("ill_retired", 32'(retired), 32'(ret_model));
            do_reset();
        end

        // Fetch stall: limit cycle with mem_ready low leads to TRAP.
        repeat (5) step(1'b0, W_FETCH_WAIT, "to_fetch_wait");
        repeat (3) step(rnd(), W_TRAP, "to_trap");
        do_reset();

        while (ret_model != 4'hF) run_vec(vecs[4]);
        check("wrap_pre", 32'(retired), 32'd15);
        run_vec(vecs[4]);
        check("wrap_zero", 32'(retired), 32'd0);

        instr = 32'hAC220008;
        step(1'b1, W_FETCH_RDY, "rstsw_fetch");
        step(rnd(), W_DECODE, "rstsw_decode");
        step(rnd(), W_EXEC_SW, "rstsw_exec");
        step(1'b0, W_MWR, "rstsw_wait0");
        step(1'b0, W_MWR, "rstsw_wait1");
        rst = 1'b1;
        step(1'b0, W_MWR, "rstsw_wait_rst");
        rst = 1'b0;
        step(1'b1, W_ZERO, "rstsw_idle");
        check("rstsw_retired", 32'(retired), 32'd0);
        ret_model = '0;
        run_vec(vecs[4]);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
